// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one external alu between NREQ requesters
// Optional: define ALU_ARB_PRIO_EN to give requester 0 absolute priority in IDLE.
module alu_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int OPW   = 3,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*OPW-1:0]   req_op,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_q,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [OPW-1:0]        alu_op,
    input  logic [WIDTH-1:0]      alu_q,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [OPW-1:0]   r_alu_op;
    logic [WIDTH-1:0] r_q;

    logic             w_found;
    logic [IDW-1:0]   w_winner;
    logic [IDW-1:0]   w_ptr_next;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [OPW-1:0]   w_sel_op;

    // Search ptr, ptr+1, ... wrapping at NREQ; first valid requester wins.
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && req_valid[idx[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = idx[IDW-1:0];
            end
        end
`ifdef ALU_ARB_PRIO_EN
        if (req_valid[0]) begin
            w_found  = 1'b1;
            w_winner = '0;
        end
`else
`endif
    end

    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_winner == IDW'(k)) begin
                w_sel_a  = req_a[k*WIDTH +: WIDTH];
                w_sel_b  = req_b[k*WIDTH +: WIDTH];
                w_sel_op = req_op[k*OPW +: OPW];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst && (r_state == ST_IDLE) && w_found) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_found) w_next = ST_EXEC;
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: if (resp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_ptr_next = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);

    // Operand registers are left holding the last operation once it completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr    <= '0;
            r_id     <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_q      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_alu_a  <= w_sel_a;
                        r_alu_b  <= w_sel_b;
                        r_alu_op <= w_sel_op;
                        r_id     <= w_winner;
                    end
                end
                ST_EXEC: r_q <= alu_q;
                ST_RESP: if (resp_ready) r_ptr <= w_ptr_next;
                default: ;
            endcase
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign resp_q     = r_q;
    assign resp_id    = r_id;
    assign resp_valid = (r_state == ST_RESP);
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int OPW   = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*OPW-1:0]   req_op;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [1:0]            resp_id;
    logic [WIDTH-1:0]      resp_q;
    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [OPW-1:0]        alu_op;
    logic [WIDTH-1:0]      alu_q;
    logic                  busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Reference alu: 0 add, 1 sub, 2 and, 3 or, 4 xor, others pass a.
    always_comb begin
        case (alu_op)
            3'd0:    alu_q = alu_a + alu_b;
            3'd1:    alu_q = alu_a - alu_b;
            3'd2:    alu_q = alu_a & alu_b;
            3'd3:    alu_q = alu_a | alu_b;
            3'd4:    alu_q = alu_a ^ alu_b;
            default: alu_q = alu_a;
        endcase
    end

    alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_q     (resp_q),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_q      (alu_q),
        .busy       (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_op[i*OPW +: OPW]    = op;
    endtask

    task automatic test_reset;
        rst        = 1'b0;
        resp_ready = 1'b0;
        req_valid  = 4'b1111;
        set_req(0, 8'd11, 8'd12, 3'd1);
        set_req(1, 8'd21, 8'd22, 3'd2);
        set_req(2, 8'd31, 8'd32, 3'd3);
        set_req(3, 8'd41, 8'd42, 3'd4);
        tick();
        tick();
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (alu_a !== 8'd0) begin n_bad++; $display("FAIL reset_alu_a: got %0d want 0", alu_a); end
        n_cmp++; if (alu_b !== 8'd0) begin n_bad++; $display("FAIL reset_alu_b: got %0d want 0", alu_b); end
        n_cmp++; if (alu_op !== 3'd0) begin n_bad++; $display("FAIL reset_alu_op: got %0d want 0", alu_op); end
        n_cmp++; if (resp_id !== 2'd0) begin n_bad++; $display("FAIL reset_resp_id: got %0d want 0", resp_id); end
        n_cmp++; if (resp_q !== 8'd0) begin n_bad++; $display("FAIL reset_resp_q: got %0d want 0", resp_q); end
        req_valid = 4'b0000;
        rst       = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single;
        set_req(2, 8'd20, 8'd5, 3'd0);
        req_valid = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_exec_busy: got %b want 1", busy); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL single_exec_ready: got %b want 0000", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL single_exec_valid: got %b want 0", resp_valid); end
        n_cmp++; if (alu_a !== 8'd20) begin n_bad++; $display("FAIL single_alu_a: got %0d want 20", alu_a); end
        n_cmp++; if (alu_b !== 8'd5) begin n_bad++; $display("FAIL single_alu_b: got %0d want 5", alu_b); end
        tick();
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL single_resp_valid: got %b want 1", resp_valid); end
        n_cmp++; if (resp_id !== 2'd2) begin n_bad++; $display("FAIL single_resp_id: got %0d want 2", resp_id); end
        n_cmp++; if (resp_q !== 8'd25) begin n_bad++; $display("FAIL single_resp_q: got %0d want 25", resp_q); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL single_done_valid: got %b want 0", resp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_done_busy: got %b want 0", busy); end
        n_cmp++; if (alu_a !== 8'd20) begin n_bad++; $display("FAIL single_alu_hold: got %0d want 20", alu_a); end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_id [5];
        logic [7:0] exp_q  [5];
        logic [3:0] exp_rdy;
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_q  = '{8'd11, 8'd18, 8'd2, 8'd44, 8'd11};
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_req(0, 8'd10, 8'd1, 3'd0);
        set_req(1, 8'd20, 8'd2, 3'd1);
        set_req(2, 8'd30, 8'd3, 3'd2);
        set_req(3, 8'd40, 8'd4, 3'd3);
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            exp_rdy = 4'b0001 << exp_id[n];
            #1;
            n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", n, req_ready, exp_rdy); end
            tick();
            n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rr_exec_ready[%0d]: got %b want 0000", n, req_ready); end
            tick();
            n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL rr_valid[%0d]: got %b want 1", n, resp_valid); end
            n_cmp++; if (resp_id !== exp_id[n]) begin n_bad++; $display("FAIL rr_id[%0d]: got %0d want %0d", n, resp_id, exp_id[n]); end
            n_cmp++; if (resp_q !== exp_q[n]) begin n_bad++; $display("FAIL rr_q[%0d]: got %0d want %0d", n, resp_q, exp_q[n]); end
            tick();
        end
        resp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        set_req(1, 8'd7, 8'd9, 3'd0);
        req_valid = 4'b0010;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b1111;
        tick();
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", c, resp_valid); end
            n_cmp++; if (resp_id !== 2'd1) begin n_bad++; $display("FAIL bp_id[%0d]: got %0d want 1", c, resp_id); end
            n_cmp++; if (resp_q !== 8'd16) begin n_bad++; $display("FAIL bp_q[%0d]: got %0d want 16", c, resp_q); end
            n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready); end
            tick();
        end
        resp_ready = 1'b1;
        #1;
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_release_valid: got %b want 1", resp_valid); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_release_ready: got %b want 0000", req_ready); end
        tick();
        resp_ready = 1'b0;
        #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_after_valid: got %b want 0", resp_valid); end
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_next_grant: got %b want 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        n_cmp++; if (resp_id !== 2'd2) begin n_bad++; $display("FAIL bp_next_id: got %0d want 2", resp_id); end
        n_cmp++; if (resp_q !== 8'd2) begin n_bad++; $display("FAIL bp_next_q: got %0d want 2", resp_q); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        set_req(2, 8'd50, 8'd60, 3'd0);
        req_valid = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL mid_grant: got %b want 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_exec_busy: got %b want 1", busy); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", resp_valid); end
        n_cmp++; if (alu_a !== 8'd0) begin n_bad++; $display("FAIL mid_alu_a: got %0d want 0", alu_a); end
        n_cmp++; if (resp_q !== 8'd0) begin n_bad++; $display("FAIL mid_resp_q: got %0d want 0", resp_q); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_resp[%0d]: got %b want 0", c, resp_valid); end
        end
        req_valid = 4'b1100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL mid_ptr_zero: got %b want 0100", req_ready); end
        set_req(1, 8'd100, 8'd30, 3'd1);
        req_valid = 4'b0010;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL mid_req1_grant: got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL mid_req1_valid: got %b want 1", resp_valid); end
        n_cmp++; if (resp_id !== 2'd1) begin n_bad++; $display("FAIL mid_req1_id: got %0d want 1", resp_id); end
        n_cmp++; if (resp_q !== 8'd70) begin n_bad++; $display("FAIL mid_req1_q: got %0d want 70", resp_q); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_prio;
        logic [3:0] exp_rdy;
        logic [1:0] exp_id;
        logic [7:0] exp_q;
`ifdef ALU_ARB_PRIO_EN
        exp_rdy = 4'b0001;
        exp_id  = 2'd0;
        exp_q   = 8'd7;
`else
        exp_rdy = 4'b0100;
        exp_id  = 2'd2;
        exp_q   = 8'd2;
`endif
        set_req(0, 8'd3, 8'd4, 3'd4);
        set_req(2, 8'd30, 8'd3, 3'd2);
        req_valid = 4'b1101;
        #1;
        n_cmp++; if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL prio_grant: got %b want %b", req_ready, exp_rdy); end
        tick();
        req_valid = 4'b0000;
        tick();
        n_cmp++; if (resp_id !== exp_id) begin n_bad++; $display("FAIL prio_id: got %0d want %0d", resp_id, exp_id); end
        n_cmp++; if (resp_q !== exp_q) begin n_bad++; $display("FAIL prio_q: got %0d want %0d", resp_q, exp_q); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_prio();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
